// File: rtl/vga_sync_ctrl.sv
// -----------------------------------------------------------------------------
// vga_sync_ctrl
//   Generates 640x480@60Hz VGA timing from the 100 MHz board clock. It drives
//   the pixel generator with a pixel-rate tick and the current coordinates, and
//   it drives the VGA connector with the sync strobes. RGB is not handled here.
//
//   Ports
//     clk         in   1   100 MHz system clock
//     reset_n     in   1   asynchronous reset, active low
//     p_tick      out  1   one-clk pulse per pixel period (registered)
//     x           out  10  current pixel column, 0..H_TOTAL-1
//     y           out  10  current line, 0..V_TOTAL-1
//     video_on    out  1   1 when x < H_DISPLAY and y < V_DISPLAY
//     hsync       out  1   horizontal sync (registered)
//     vsync       out  1   vertical sync (registered)
//   Only when VGA_FRAME_CNT_EN is defined:
//     frame_tick  out  1   one-clk pulse in the clk where x,y wrap to (0,0)
//     frame_cnt   out  16  number of completed frames since reset, wraps
//
//   Configuration macro: VGA_FRAME_CNT_EN. It adds the frame_tick and
//   frame_cnt ports and logic. When it is undefined, those ports are absent.
//
//   The H_TOTAL and V_TOTAL parameter sums must not exceed 1024.
// -----------------------------------------------------------------------------
module vga_sync_ctrl #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned H_DISPLAY   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_DISPLAY   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic        frame_tick,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Each region starts where the previous one ends.
   localparam logic [9:0] H_FRONT_START = 10'(H_DISPLAY);
   localparam logic [9:0] H_SYNC_START  = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_BACK_START  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);

   localparam logic [9:0] V_FRONT_START = 10'(V_DISPLAY);
   localparam logic [9:0] V_SYNC_START  = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_BACK_START  = 10'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      R_DISPLAY,
      R_FRONT,
      R_SYNC,
      R_BACK
   } region_t;

   function automatic region_t h_region(input logic [9:0] px);
      if (px < H_FRONT_START)     return R_DISPLAY;
      else if (px < H_SYNC_START) return R_FRONT;
      else if (px < H_BACK_START) return R_SYNC;
      else                        return R_BACK;
   endfunction

   function automatic region_t v_region(input logic [9:0] ln);
      if (ln < V_FRONT_START)     return R_DISPLAY;
      else if (ln < V_SYNC_START) return R_FRONT;
      else if (ln < V_BACK_START) return R_SYNC;
      else                        return R_BACK;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       x_next;
   logic [9:0]       y_next;
   logic             frame_wrap;

   // Next-state coordinates. The registered p_tick is the advance enable, so
   // x,y stay stable for the whole pixel period in which p_tick is high.
   always_comb begin
      x_next     = x;
      y_next     = y;
      frame_wrap = 1'b0;
      if (p_tick) begin
         if (x == H_LAST) begin
            x_next = '0;
            if (y == V_LAST) begin
               y_next     = '0;
               frame_wrap = 1'b1;
            end else begin
               y_next = y + 10'd1;
            end
         end else begin
            x_next = x + 10'd1;
         end
      end
   end

   // The sync outputs are decoded from the next-state coordinates, so each
   // sync flop updates in the same clk as x,y and never glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         p_tick  <= 1'b0;
         x       <= '0;
         y       <= '0;
         hsync   <= ~SYNC_ACTIVE;
         vsync   <= ~SYNC_ACTIVE;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         p_tick  <= (div_cnt == DIV_LAST);
         x       <= x_next;
         y       <= y_next;
         hsync   <= (h_region(x_next) == R_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync   <= (v_region(y_next) == R_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
   end

   always_comb begin
      video_on = (h_region(x) == R_DISPLAY) && (v_region(y) == R_DISPLAY);
   end

`ifdef VGA_FRAME_CNT_EN
   // The counter advances on the same edge that raises frame_tick. As a
   // result, frame_cnt already includes the frame that ends in that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_tick <= frame_wrap;
         if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_frame_wrap;
   always_comb begin
      unused_frame_wrap = frame_wrap;
   end
`endif

endmodule
